// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage signal bundle: MEM-side inputs, register-file write and forwarding outputs
interface mem_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic                  in_link;
  logic [REG_ADDR_W-1:0] in_write_reg;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_pc_plus4;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rdata_valid;
  logic                  flush;

  logic                  stall_out;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_reg;
  logic [DATA_W-1:0]     fwd_data;
  logic [31:0]           retired_count;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_link, in_write_reg,
           in_alu_result, in_pc_plus4, mem_rdata, mem_rdata_valid, flush,
    input  stall_out, reg_write, write_reg, write_data,
           fwd_valid, fwd_reg, fwd_data, retired_count
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_link, in_write_reg,
           in_alu_result, in_pc_plus4, mem_rdata, mem_rdata_valid, flush,
    output stall_out, reg_write, write_reg, write_data,
           fwd_valid, fwd_reg, fwd_data, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS MEM/WB stage: write-back select, $0 suppression, multi-cycle load stall FSM
// Optional retired-instruction counter enabled by MEM_WB_RETIRE_COUNT_EN.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_wb_valid;
  logic                  r_wb_reg_write;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0]     r_write_data;
  logic                  r_pend_reg_write;
  logic [REG_ADDR_W-1:0] r_pend_write_reg;

  logic                  w_capture;
  logic                  w_load_wait;
  logic                  w_load_done;
  logic                  w_stall;
  logic                  w_reg_write;
  logic [DATA_W-1:0]     w_capture_data;

  assign w_capture   = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
  assign w_load_wait = w_capture && bus.in_mem_to_reg && !bus.mem_rdata_valid;
  assign w_load_done = (r_state == S_WAIT_MEM) && bus.mem_rdata_valid;

  assign w_capture_data = bus.in_mem_to_reg ? bus.mem_rdata :
                          bus.in_link       ? bus.in_pc_plus4 :
                                              bus.in_alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_load_wait)          w_next_state = S_WAIT_MEM;
      S_WAIT_MEM: if (bus.mem_rdata_valid)  w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    if (r_state == S_WAIT_MEM) begin
      w_stall = 1'b1;
    end
  end

  // Pending destination is kept apart so write_reg/write_data hold while the load waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid       <= 1'b0;
      r_wb_reg_write   <= 1'b0;
      r_write_reg      <= '0;
      r_write_data     <= '0;
      r_pend_reg_write <= 1'b0;
      r_pend_write_reg <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_load_done) begin
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= r_pend_reg_write;
        r_write_reg    <= r_pend_write_reg;
        r_write_data   <= bus.mem_rdata;
      end else if (w_load_wait) begin
        r_pend_reg_write <= bus.in_reg_write;
        r_pend_write_reg <= bus.in_write_reg;
      end else if (w_capture) begin
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= bus.in_reg_write;
        r_write_reg    <= bus.in_write_reg;
        r_write_data   <= w_capture_data;
      end
    end
  end

  assign w_reg_write = r_wb_valid && r_wb_reg_write && (r_write_reg != '0);

  assign bus.stall_out  = w_stall;
  assign bus.reg_write  = w_reg_write;
  assign bus.write_reg  = r_write_reg;
  assign bus.write_data = r_write_data;
  assign bus.fwd_valid  = w_reg_write;
  assign bus.fwd_reg    = r_write_reg;
  assign bus.fwd_data   = r_write_data;

`ifdef MEM_WB_RETIRE_COUNT_EN
  logic [31:0] r_retired_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_count <= '0;
    end else if (r_wb_valid) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign bus.retired_count = r_retired_count;
`else
  assign bus.retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed and randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic clk;
  logic rst;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding load at most, one retirement presented per cycle.
  bit          m_pending;
  bit          p_rw;
  logic [4:0]  p_reg;
  bit          m_wv;
  bit          m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input bit lnk,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rd, input bit rdv, input bit fl);
    bus.in_valid        = v;
    bus.in_reg_write    = rw;
    bus.in_mem_to_reg   = m2r;
    bus.in_link         = lnk;
    bus.in_write_reg    = wr;
    bus.in_alu_result   = alu;
    bus.in_pc_plus4     = pc4;
    bus.mem_rdata       = rd;
    bus.mem_rdata_valid = rdv;
    bus.flush           = fl;
  endtask

  task automatic model_reset();
    m_pending = 0; p_rw = 0; p_reg = '0;
    m_wv = 0; m_rw = 0; m_reg = '0; m_data = '0; m_cnt = '0;
  endtask

  // Called at a negedge with inputs already applied; checks stall, advances one edge, checks outputs.
  task automatic cycle(input string tag);
    logic exp_rw;
    chk({tag, ".stall"}, {31'd0, bus.stall_out}, {31'd0, m_pending});
    if (rst) begin
      model_reset();
    end else begin
      if (m_wv) m_cnt = m_cnt + 32'd1;
      m_wv = 0;
      if (m_pending) begin
        if (bus.mem_rdata_valid) begin
          m_pending = 0; m_wv = 1; m_rw = p_rw; m_reg = p_reg; m_data = bus.mem_rdata;
        end
      end else if (bus.in_valid && !bus.flush) begin
        if (bus.in_mem_to_reg && !bus.mem_rdata_valid) begin
          m_pending = 1; p_rw = bus.in_reg_write; p_reg = bus.in_write_reg;
        end else begin
          m_wv = 1; m_rw = bus.in_reg_write; m_reg = bus.in_write_reg;
          m_data = bus.in_mem_to_reg ? bus.mem_rdata :
                   bus.in_link       ? bus.in_pc_plus4 : bus.in_alu_result;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    exp_rw = m_wv && m_rw && (m_reg != 5'd0);
    chk({tag, ".reg_write"},  {31'd0, bus.reg_write},  {31'd0, exp_rw});
    chk({tag, ".write_reg"},  {27'd0, bus.write_reg},  {27'd0, m_reg});
    chk({tag, ".write_data"}, bus.write_data,          m_data);
    chk({tag, ".fwd_valid"},  {31'd0, bus.fwd_valid},  {31'd0, exp_rw});
    chk({tag, ".fwd_reg"},    {27'd0, bus.fwd_reg},    {27'd0, m_reg});
    chk({tag, ".fwd_data"},   bus.fwd_data,            m_data);
`ifdef MEM_WB_RETIRE_COUNT_EN
    chk({tag, ".retired"},    bus.retired_count,       m_cnt);
`else
    chk({tag, ".retired"},    bus.retired_count,       32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cycle("reset");
    chk("reset.write_data_zero", bus.write_data, 32'd0);
    rst = 1'b0;

    // Non-load add to $8
    drive(1, 1, 0, 0, 5'd8, 32'h0000_0010, 32'h0000_1004, 32'hAAAA_AAAA, 1, 0);
    cycle("add");
    chk("add.data_const", bus.write_data, 32'h0000_0010);
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    cycle("add_idle");

    // Single-cycle load
    drive(1, 1, 1, 0, 5'd9, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1, 0);
    cycle("ld1");
    chk("ld1.data_const", bus.write_data, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    cycle("ld1_idle");

    // Multi-cycle load to $10; instructions offered during the stall must be ignored
    drive(1, 1, 1, 0, 5'd10, 32'h0000_0200, 32'd0, 32'h0BAD_0BAD, 0, 0);
    cycle("ldm_cap");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd11, 32'h5555_0000 + i, 32'd0, 32'hFFFF_0000, 0, i == 1);
      cycle("ldm_wait");
    end
    drive(1, 1, 0, 0, 5'd12, 32'h7777_7777, 32'd0, 32'h1234_5678, 1, 0);
    chk("ldm.stall_on_done", {31'd0, bus.stall_out}, 32'd1);
    cycle("ldm_done");
    chk("ldm.data_const", bus.write_data, 32'h1234_5678);
    drive(1, 1, 0, 0, 5'd13, 32'h0000_0013, 32'd0, 32'd0, 0, 0);
    cycle("ldm_next");

    // $0 write suppressed, then flush in IDLE
    drive(1, 1, 0, 0, 5'd0, 32'hCAFE_0000, 32'd0, 32'd0, 0, 0);
    cycle("zero_reg");
    drive(1, 1, 0, 0, 5'd14, 32'h0000_0014, 32'd0, 32'd0, 0, 1);
    cycle("flush");
    chk("flush.no_write", {31'd0, bus.reg_write}, 32'd0);

    // jal link value
    drive(1, 1, 0, 1, 5'd31, 32'h0000_0999, 32'h0000_0040, 32'd0, 0, 0);
    cycle("jal");
    chk("jal.data_const", bus.write_data, 32'h0000_0040);

    // Reset while a load is pending
    drive(1, 1, 1, 0, 5'd15, 32'd0, 32'd0, 32'd0, 0, 0);
    cycle("rst_cap");
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'h9999_9999, 1, 0);
    rst = 1'b1;
    cycle("rst_wait");
    rst = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    chk("rst.stall_clear", {31'd0, bus.stall_out}, 32'd0);
    chk("rst.data_clear", bus.write_data, 32'd0);
    cycle("rst_after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
